// File: rtl/sram_stream_reader_pkg.sv
// Shared types for the SRAM stream reader: controller states and the read latency it is built around.
package sram_stream_reader_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } rd_state_t;

  localparam int SRAM_RD_LATENCY = 1;

endpackage

// File: rtl/sram_stream_reader_if.sv
// Bus bundle between the reader, the operand SRAM macro and the downstream stream sink.
interface sram_stream_reader_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
);
  logic              sram_cs;
  logic              sram_we;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_din;
  logic [DATA_W-1:0] sram_dout;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_last;

  modport master (
    output sram_cs, sram_we, sram_addr, sram_din,
    input  sram_dout,
    output m_valid, m_data, m_last,
    input  m_ready
  );

  modport slave (
    input  sram_cs, sram_we, sram_addr, sram_din,
    output sram_dout,
    input  m_valid, m_data, m_last,
    output m_ready
  );
endinterface

// File: rtl/sram_stream_reader_stream_fifo.sv
// Small synchronous FIFO with head-of-queue output; same-cycle push and pop allowed.
module stream_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 3,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic             do_pop;
  logic             full;

  assign full   = (count == CW'(DEPTH));
  assign do_pop = pop && (count != '0);
  assign head   = mem[rd_ptr];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // The reader's credit check must make this impossible.
  assert property (@(posedge clk) disable iff (!rst_n) !(push && full));

endmodule

// File: rtl/sram_stream_reader.sv
// Streams len consecutive SRAM words from base_addr into a valid/ready stream,
// buffering through a small FIFO so reads are only issued when space is guaranteed.
//
// state | meaning
// IDLE  | waiting for start; base/len captured on start
// RUN   | issuing reads and draining the FIFO until the last beat handshakes
// DONE  | one-cycle done pulse, start ignored
module sram_stream_reader
  import sram_stream_reader_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 4,
  parameter int FIFO_DEPTH = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W:0]     len,
  output logic                busy,
  output logic                done,
  sram_stream_reader_if.master bus
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  rd_state_t         state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q;
  logic [ADDR_W:0]   len_q, issued_q;
  logic              inflight_q, inflight_last_q;
  logic [CW-1:0]     fifo_count;
  logic [DATA_W:0]   fifo_head;
  logic [CW:0]       occupancy;
  logic              issue, pop, last_hs, accept;

  // Words in flight from the SRAM count against FIFO space before they land.
  assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q};
  assign issue     = (state_q == RUN) && (issued_q < len_q) && (occupancy < (CW+1)'(FIFO_DEPTH));
  assign accept    = (state_q == IDLE) && start;

  assign bus.m_valid = (fifo_count != '0);
  assign bus.m_data  = bus.m_valid ? fifo_head[DATA_W-1:0] : '0;
  assign bus.m_last  = bus.m_valid && fifo_head[DATA_W];
  assign pop         = bus.m_valid && bus.m_ready;
  assign last_hs     = pop && fifo_head[DATA_W];

  assign bus.sram_cs   = issue;
  assign bus.sram_we   = 1'b0;
  assign bus.sram_addr = issue ? cur_addr_q : '0;
  assign bus.sram_din  = '0;

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (len == '0) ? DONE : RUN;
      RUN:     if (last_hs) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      cur_addr_q      <= '0;
      len_q           <= '0;
      issued_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cur_addr_q <= base_addr;
        len_q      <= len;
        issued_q   <= '0;
      end else if (issue) begin
        cur_addr_q <= cur_addr_q + 1'b1;
        issued_q   <= issued_q + 1'b1;
      end
      // Single-stage capture pipeline matching SRAM_RD_LATENCY.
      inflight_q      <= issue;
      inflight_last_q <= issue && (issued_q == len_q - 1'b1);
    end
  end

  stream_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (inflight_q),
    .pop   (pop),
    .wdata ({inflight_last_q, bus.sram_dout}),
    .head  (fifo_head),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_sram_stream_reader.sv
// Directed bench for sram_stream_reader with a behavioural 1-cycle-read SRAM model.
module tb_sram_stream_reader;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] base_addr = '0;
  logic [4:0] len = '0;
  logic       busy, done;
  logic [31:0] mem [16];

  int n_checks = 0;
  int n_fail   = 0;

  sram_stream_reader_if #(.DATA_W(32), .ADDR_W(4)) bus ();

  sram_stream_reader #(.DATA_W(32), .ADDR_W(4), .FIFO_DEPTH(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (bus.sram_cs && !bus.sram_we) bus.sram_dout <= mem[bus.sram_addr];

  typedef struct {
    logic [3:0]  base;
    logic [4:0]  len;
    int          mode;      // 0 ready high, 1 stall 6 cycles after beat 2, 2 random ready
    bit          mid_start;
    logic [31:0] exp_first;
    logic [31:0] exp_last;
  } vec_t;

  vec_t tbl [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] word_at(input int a);
    return 32'hA000_0000 + 32'(a % 16);
  endfunction

  task automatic run_xfer(input vec_t v);
    int cyc = 0, beats = 0, issued = 0, first_cs = -1, first_v = -1;
    int last_hs = -1, done_cyc = -1, stall_left = 0;
    logic [15:0] seen = '0;
    logic [31:0] prev_data = '0;
    bit prev_stall = 0;
    bit busy_at_done = 1;
    @(negedge clk);
    start = 1'b1; base_addr = v.base; len = v.len;
    while (done_cyc < 0 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      start = v.mid_start && (cyc == 5);
      if (start) begin base_addr = 4'd9; len = 5'd1; end
      case (v.mode)
        1: begin bus.m_ready = (stall_left == 0); if (stall_left > 0) stall_left--; end
        2: bus.m_ready = 1'($urandom_range(0, 1));
        default: bus.m_ready = 1'b1;
      endcase
      if (prev_stall) begin
        check("hold_valid", 64'(bus.m_valid), 64'd1);
        check("hold_data", 64'(bus.m_data), 64'(prev_data));
      end
      if (bus.sram_cs) begin
        if (first_cs < 0) first_cs = cyc;
        check("sram_addr", 64'(bus.sram_addr), 64'((int'(v.base) + issued) % 16));
        seen[bus.sram_addr] = 1'b1;
        issued++;
      end
      if (bus.m_valid && !bus.m_ready) check("outstanding_le_3", 64'(issued - beats <= 3), 64'd1);
      if (done) begin done_cyc = cyc; busy_at_done = busy; end
      if (bus.m_valid && first_v < 0) first_v = cyc;
      if (bus.m_valid && bus.m_ready) begin
        check("beat_data", 64'(bus.m_data), 64'(word_at(int'(v.base) + beats)));
        if (beats == 0) check("first_data", 64'(bus.m_data), 64'(v.exp_first));
        if (beats == int'(v.len) - 1) check("last_data", 64'(bus.m_data), 64'(v.exp_last));
        check("m_last", 64'(bus.m_last), 64'(beats == int'(v.len) - 1));
        beats++;
        last_hs = cyc;
        if (v.mode == 1 && beats == 2) stall_left = 6;
      end
      prev_stall = bus.m_valid && !bus.m_ready;
      prev_data  = bus.m_data;
    end
    start = 1'b0;
    if (done_cyc < 0) begin
      n_checks++; n_fail++;
      $display("FAIL done_timeout: no done within 300 cycles (base %0d len %0d)", v.base, v.len);
    end
    check("beat_count", 64'(beats), 64'(v.len));
    check("issue_count", 64'(issued), 64'(v.len));
    check("first_cs_cycle", 64'(first_cs), (v.len != 0) ? 64'd1 : 64'(-1));
    check("first_valid_cycle", 64'(first_v), (v.len != 0) ? 64'd3 : 64'(-1));
    check("done_cycle", 64'(done_cyc), (v.len != 0) ? 64'(last_hs + 1) : 64'd1);
    check("busy_low_in_done", 64'(busy_at_done), 64'd0);
    if (v.mode == 0 && v.len != 0) check("back_to_back", 64'(last_hs), 64'(int'(v.len) + 2));
    if (v.len == 16) check("all_addr_once", 64'(seen), 64'hFFFF);
    @(negedge clk);
    check("done_one_cycle", 64'(done), 64'd0);
    check("idle_after_done", 64'(busy), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'hA000_0000 + 32'(i);
    bus.m_ready = 1'b1;

    tbl[0] = '{base: 4'd2,  len: 5'd4,  mode: 0, mid_start: 0, exp_first: 32'hA000_0002, exp_last: 32'hA000_0005};
    tbl[1] = '{base: 4'd0,  len: 5'd8,  mode: 1, mid_start: 0, exp_first: 32'hA000_0000, exp_last: 32'hA000_0007};
    tbl[2] = '{base: 4'd14, len: 5'd4,  mode: 0, mid_start: 0, exp_first: 32'hA000_000E, exp_last: 32'hA000_0001};
    tbl[3] = '{base: 4'd3,  len: 5'd0,  mode: 0, mid_start: 0, exp_first: 32'h0,          exp_last: 32'h0};
    tbl[4] = '{base: 4'd0,  len: 5'd16, mode: 2, mid_start: 1, exp_first: 32'hA000_0000, exp_last: 32'hA000_000F};
    tbl[5] = '{base: 4'd7,  len: 5'd1,  mode: 0, mid_start: 0, exp_first: 32'hA000_0007, exp_last: 32'hA000_0007};

    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_cs", 64'(bus.sram_cs), 64'd0);
    check("rst_valid", 64'(bus.m_valid), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("we_tied", 64'(bus.sram_we), 64'd0);
    check("din_tied", 64'(bus.sram_din), 64'd0);
    check("idle_addr", 64'(bus.sram_addr), 64'd0);
    check("idle_data", 64'(bus.m_data), 64'd0);

    for (int t = 0; t < 6; t++) run_xfer(tbl[t]);

    // start held into DONE must not launch a second transfer
    @(negedge clk); start = 1'b1; base_addr = 4'd3; len = 5'd0;
    @(negedge clk); check("len0_done", 64'(done), 64'd1); check("len0_cs", 64'(bus.sram_cs), 64'd0);
    len = 5'd3;
    @(negedge clk); check("done_start_ignored", 64'(busy), 64'd0); check("done_pulse_end", 64'(done), 64'd0);
    start = 1'b0;
    @(negedge clk); check("len0_no_valid", 64'(bus.m_valid), 64'd0);

    // reset while beat 3 is presented
    begin
      int hs = 0, cyc = 0;
      @(negedge clk); start = 1'b1; base_addr = 4'd0; len = 5'd8; bus.m_ready = 1'b1;
      while (hs < 2 && cyc < 50) begin
        @(negedge clk); cyc++; start = 1'b0;
        if (bus.m_valid && bus.m_ready) hs++;
      end
      @(negedge clk);
      check("beat3_present", 64'(bus.m_data), 64'hA000_0002);
      rst_n = 1'b0;
      #1;
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_done", 64'(done), 64'd0);
      check("abort_cs", 64'(bus.sram_cs), 64'd0);
      check("abort_addr", 64'(bus.sram_addr), 64'd0);
      check("abort_valid", 64'(bus.m_valid), 64'd0);
      check("abort_data", 64'(bus.m_data), 64'd0);
      check("abort_last", 64'(bus.m_last), 64'd0);
      @(negedge clk); rst_n = 1'b1;
    end
    run_xfer('{base: 4'd5, len: 5'd2, mode: 0, mid_start: 0, exp_first: 32'hA000_0005, exp_last: 32'hA000_0006});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
